swc_rtu_port_arbiter: RTL

//  Shares one RTU lookup engine between g_num_ports switch-core input ports. Grants
//  per-port lookup requests round-robin and keeps one lookup outstanding at a time.

---
 rtl/swc_rtu_port_arbiter_pkg.sv | 27 ++
 rtl/swc_rtu_port_arbiter_if.sv | 25 ++
 rtl/swc_rtu_port_arbiter_rr.sv | 41 ++++
 rtl/swc_rtu_port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/swc_rtu_port_arbiter_pkg.sv
// rtl/swc_rtu_port_arbiter_pkg.sv - shared types and helpers for the RTU port arbiter
package swc_rtu_arb_pkg;

    localparam int C_MAX_PORTS = 32;
    localparam int C_MAX_PRIO  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } arb_state_t;

    // Sized for the largest supported switch; users slice down to g_num_ports/g_prio_width.
    typedef struct packed {
        logic [C_MAX_PORTS-1:0] mask;
        logic                   drop;
        logic [C_MAX_PRIO-1:0]  prio;
    } rtu_rsp_t;

    function automatic int f_log2c(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/swc_rtu_port_arbiter_if.sv
// rtl/swc_rtu_port_arbiter_if.sv - request/response channel between arbiter and RTU engine
interface swc_rtu_port_arbiter_if #(
    parameter int N  = 7,
    parameter int P  = 3,
    parameter int PW = 3
);
    logic          rtu_req_valid;
    logic [P-1:0]  rtu_req_port;
    logic          rtu_req_ready;
    logic          rtu_rsp_valid;
    logic [P-1:0]  rtu_rsp_port;
    logic [N-1:0]  rtu_rsp_mask;
    logic          rtu_rsp_drop;
    logic [PW-1:0] rtu_rsp_prio;

    modport master (
        output rtu_req_valid, rtu_req_port,
        input  rtu_req_ready, rtu_rsp_valid, rtu_rsp_port, rtu_rsp_mask, rtu_rsp_drop, rtu_rsp_prio
    );

    modport slave (
        input  rtu_req_valid, rtu_req_port,
        output rtu_req_ready, rtu_rsp_valid, rtu_rsp_port, rtu_rsp_mask, rtu_rsp_drop, rtu_rsp_prio
    );
endinterface

// File: rtl/swc_rtu_port_arbiter_rr.sv
// rtl/swc_rtu_port_arbiter_rr.sv - round-robin pick of the first request at or after the pointer
module swc_rr_arbiter #(
    parameter int g_n  = 7,
    parameter int g_iw = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [g_n-1:0]  req_i,
    input  logic            advance_i,
    input  logic [g_iw-1:0] adv_idx_i,
    output logic [g_n-1:0]  grant_o,
    output logic [g_iw-1:0] idx_o,
    output logic            any_o
);
    logic [g_iw-1:0] ptr;
    logic [g_iw:0]   j;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ptr <= '0;
        else if (advance_i)
            ptr <= (adv_idx_i == g_iw'(g_n - 1)) ? '0 : adv_idx_i + 1'b1;
    end

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int k = 0; k < g_n; k++) begin
            j = {1'b0, ptr} + (g_iw+1)'(k);
            if (j >= (g_iw+1)'(g_n))
                j = j - (g_iw+1)'(g_n);
            if (!any_o && req_i[j[g_iw-1:0]]) begin
                any_o                  = 1'b1;
                grant_o[j[g_iw-1:0]]   = 1'b1;
                idx_o                  = j[g_iw-1:0];
            end
        end
    end
endmodule

// File: rtl/swc_rtu_port_arbiter.sv
// rtl/swc_rtu_port_arbiter.sv - shares one RTU lookup engine between switch ports, one lookup in flight
module swc_rtu_port_arbiter
    import swc_rtu_arb_pkg::*;
#(
    parameter int g_num_ports  = 7,
    parameter int g_prio_width = 3,
    parameter int g_timeout    = 1023
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [g_num_ports-1:0]               port_req_i,
    output logic [g_num_ports-1:0]               port_req_ack_o,
    swc_rtu_port_arbiter_if.master               rtu,
    output logic [g_num_ports-1:0]               core_rsp_valid_o,
    input  logic [g_num_ports-1:0]               core_rsp_ack_i,
    output logic [g_num_ports*g_num_ports-1:0]   core_dst_mask_o,
    output logic [g_num_ports-1:0]               core_drop_o,
    output logic [g_num_ports*g_prio_width-1:0]  core_prio_o,
    output logic                                 timeout_o,
    output logic                                 rsp_err_o
);
    localparam int N  = g_num_ports;
    localparam int PW = g_prio_width;
    localparam int P  = f_log2c(N);
    localparam int CW = f_log2c(g_timeout + 1);

    arb_state_t    state, state_nxt;
    logic [P-1:0]  idx_q;
    logic [N-1:0]  grant_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  slot_vld;
    rtu_rsp_t      slot [N];
    rtu_rsp_t      rsp_rec;

    logic [N-1:0]  elig, grant_oh;
    logic [P-1:0]  grant_idx;
    logic          any_elig, accept, rsp_hit, rsp_bad, tmo;

    // A port whose slot is still held by swc_core must not be granted again.
    assign elig = port_req_i & ~slot_vld;

    swc_rr_arbiter #(.g_n(N), .g_iw(P)) u_rr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (elig),
        .advance_i (accept),
        .adv_idx_i (idx_q),
        .grant_o   (grant_oh),
        .idx_o     (grant_idx),
        .any_o     (any_elig)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        rsp_hit           = 1'b0;
        tmo               = 1'b0;
        rsp_bad           = rtu.rtu_rsp_valid;
        rtu.rtu_req_valid = 1'b0;
        port_req_ack_o    = '0;
        case (state)
            IDLE:
                if (any_elig) state_nxt = ISSUE;
            ISSUE: begin
                rtu.rtu_req_valid = 1'b1;
                if (rtu.rtu_req_ready) begin
                    accept         = 1'b1;
                    port_req_ack_o = grant_q;
                    state_nxt      = WAIT_RSP;
                end
            end
            WAIT_RSP:
                // A matching response in the timeout cycle still wins.
                if (rtu.rtu_rsp_valid && rtu.rtu_rsp_port == idx_q) begin
                    rsp_hit   = 1'b1;
                    rsp_bad   = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CW'(g_timeout - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            default:
                state_nxt = IDLE;
        endcase
    end

    assign rtu.rtu_req_port = idx_q;

    always_comb begin
        rsp_rec = '0;
        if (rsp_hit) begin
            rsp_rec.mask[N-1:0]  = rtu.rtu_rsp_mask;
            rsp_rec.drop         = rtu.rtu_rsp_drop;
            rsp_rec.prio[PW-1:0] = rtu.rtu_rsp_prio;
        end else begin
            rsp_rec.drop = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q     <= '0;
            grant_q   <= '0;
            cnt       <= '0;
            slot_vld  <= '0;
            timeout_o <= 1'b0;
            rsp_err_o <= 1'b0;
            for (int i = 0; i < N; i++) slot[i] <= '0;
        end else begin
            timeout_o <= tmo;
            rsp_err_o <= rsp_bad;
            if (state == IDLE && any_elig) begin
                idx_q   <= grant_idx;
                grant_q <= grant_oh;
            end
            if (accept)
                cnt <= '0;
            else if (state == WAIT_RSP)
                cnt <= cnt + 1'b1;
            slot_vld <= slot_vld & ~core_rsp_ack_i;
            if (rsp_hit || tmo) begin
                slot_vld[idx_q] <= 1'b1;
                slot[idx_q]     <= rsp_rec;
            end
        end
    end

    assign core_rsp_valid_o = slot_vld;

    always_comb begin
        core_dst_mask_o = '0;
        core_drop_o     = '0;
        core_prio_o     = '0;
        for (int i = 0; i < N; i++) begin
            core_dst_mask_o[i*N +: N]  = slot[i].mask[N-1:0];
            core_drop_o[i]             = slot[i].drop;
            core_prio_o[i*PW +: PW]    = slot[i].prio[PW-1:0];
        end
    end
endmodule
